// File: rtl/death_seq_pkg.sv
// Shared types and default constants for the Pac-Man death sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package death_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FREEZE    = 3'd1,
    ANIM      = 3'd2,
    RESPAWN   = 3'd3,
    READY     = 3'd4,
    GAME_OVER = 3'd5
  } death_state_t;

  localparam int DEF_FREEZE_FRAMES  = 60;
  localparam int DEF_ANIM_STEP_FRMS = 8;
  localparam int DEF_ANIM_STEPS     = 11;
  localparam int DEF_READY_FRAMES   = 120;
  localparam int ANIM_STEP_W        = 4;

  // Blink half-period of the READY banner, in counted frames.
  localparam int BLINK_FRAMES = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/death_sequencer_if.sv
// Bundle between game_control (inputs) and the actor/graphics side (outputs) of the death sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are pulses or levels.
interface death_sequencer_if;
  import death_seq_pkg::*;

  logic                   start_of_frame;
  logic                   game_started;
  logic                   lost_life;
  logic [2:0]             lives;
  logic                   freeze;
  logic                   pm_death_anim;
  logic [ANIM_STEP_W-1:0] anim_step;
  logic                   ghosts_hidden;
  logic                   respawn;
  logic                   ready_banner;
  logic                   game_over;

  // Game-control side: drives frame timing and life events, observes sequence outputs.
  modport master (
    output start_of_frame, game_started, lost_life, lives,
    input  freeze, pm_death_anim, anim_step, ghosts_hidden, respawn, ready_banner, game_over
  );

  // Sequencer side.
  modport slave (
    input  start_of_frame, game_started, lost_life, lives,
    output freeze, pm_death_anim, anim_step, ghosts_hidden, respawn, ready_banner, game_over
  );

endinterface

// File: rtl/frame_tick_counter.sv
// Counts start_of_frame ticks with a synchronous clear; flags the tick that reaches a runtime limit.
// Latency: tc is combinational from tick/count; count updates one cycle after the tick.
// Backpressure: none.
module frame_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  // tc deliberately ignores clr: the parent derives clr from tc, so gating here would form a loop.
  assign tc = tick && (count == limit - 1'b1);

  // Clear has priority over counting so a state entry always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (clr)  count <= '0;
    else if (tick) count <= count + 1'b1;
  end

endmodule

// File: rtl/death_sequencer.sv
// Runs the frame-timed death sequence: freeze, death animation, then respawn+READY or game over.
// Latency: every output is registered from the next-state decode, so it moves on the same edge as the FSM.
// Backpressure: none; lost_life outside IDLE is dropped. Optional READY blink: DEATH_SEQ_BLINK_EN.
module death_sequencer
  import death_seq_pkg::*;
#(
  parameter int FREEZE_FRAMES  = DEF_FREEZE_FRAMES,
  parameter int ANIM_STEP_FRMS = DEF_ANIM_STEP_FRMS,
  parameter int ANIM_STEPS     = DEF_ANIM_STEPS,
  parameter int READY_FRAMES   = DEF_READY_FRAMES
) (
  input logic               clk,
  input logic               reset,
  death_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(max3(FREEZE_FRAMES, ANIM_STEP_FRMS, READY_FRAMES)) + 1;

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_FREEZE    = FREEZE;
  localparam logic [2:0] S_ANIM      = ANIM;
  localparam logic [2:0] S_RESPAWN   = RESPAWN;
  localparam logic [2:0] S_READY     = READY;
  localparam logic [2:0] S_GAME_OVER = GAME_OVER;

  localparam logic [ANIM_STEP_W-1:0] LAST_STEP = ANIM_STEP_W'(ANIM_STEPS - 1);

  logic [2:0]             state, next_state;
  logic [ANIM_STEP_W-1:0] step, step_nxt;
  logic                   step_adv;
  logic [CNT_W-1:0]       limit;
  logic                   tc;
  logic                   cnt_clr;
  logic                   banner_nxt;

  logic                   freeze_q, anim_q, hidden_q, respawn_q, banner_q, over_q;
  logic [ANIM_STEP_W-1:0] step_q;

  // Pick the frame limit that applies to the current state.
  always_comb begin
    limit = CNT_W'(1);
    case (state)
      S_FREEZE: limit = CNT_W'(FREEZE_FRAMES);
      S_ANIM:   limit = CNT_W'(ANIM_STEP_FRMS);
      S_READY:  limit = CNT_W'(READY_FRAMES);
      default:  limit = CNT_W'(1);
    endcase
  end

  // Counter restarts on every state entry and every animation step; held at zero where nothing is timed.
  assign cnt_clr = (next_state != state) || step_adv ||
                   (state == S_IDLE) || (state == S_RESPAWN) || (state == S_GAME_OVER);

  frame_tick_counter #(.W(CNT_W)) u_frames (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .tick  (bus.start_of_frame),
    .limit (limit),
    .tc    (tc)
  );

  // Next-state and animation-step decode; dropping game_started overrides everything.
  always_comb begin
    next_state = state;
    step_nxt   = step;
    step_adv   = 1'b0;
    if (!bus.game_started) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (bus.lost_life) next_state = S_FREEZE;
        S_FREEZE:    if (tc) next_state = S_ANIM;
        S_ANIM: begin
          if (tc) begin
            if (step == LAST_STEP) begin
              // lives is only looked at here, once the last frame of the animation has been shown.
              next_state = (bus.lives == 3'd0) ? S_GAME_OVER : S_RESPAWN;
            end else begin
              step_nxt = step + 1'b1;
              step_adv = 1'b1;
            end
          end
        end
        S_RESPAWN:   next_state = S_READY;
        S_READY:     if (tc) next_state = S_IDLE;
        S_GAME_OVER: next_state = S_GAME_OVER;
        default:     next_state = S_IDLE;
      endcase
    end
    if (next_state != S_ANIM) step_nxt = '0;
  end

  // FSM state and animation step registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      step  <= '0;
    end else begin
      state <= next_state;
      step  <= step_nxt;
    end
  end

`ifdef DEATH_SEQ_BLINK_EN
  logic [3:0] blink_cnt, blink_cnt_nxt;
  logic       blink_on, blink_on_nxt;

  // Banner phase: on at READY entry, flips after each BLINK_FRAMES counted frames in READY.
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    if ((next_state == S_READY) && (state != S_READY)) begin
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else if ((state == S_READY) && bus.start_of_frame) begin
      blink_cnt_nxt = blink_cnt + 1'b1;
      if (blink_cnt == 4'(BLINK_FRAMES - 1)) blink_on_nxt = ~blink_on;
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
    end
  end

  assign banner_nxt = (next_state == S_READY) && blink_on_nxt;
`else
  assign banner_nxt = (next_state == S_READY);
`endif

  // Output registers decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze_q  <= 1'b0;
      anim_q    <= 1'b0;
      hidden_q  <= 1'b0;
      respawn_q <= 1'b0;
      banner_q  <= 1'b0;
      over_q    <= 1'b0;
      step_q    <= '0;
    end else begin
      freeze_q  <= (next_state != S_IDLE);
      anim_q    <= (next_state == S_ANIM);
      hidden_q  <= (next_state == S_ANIM) || (next_state == S_GAME_OVER);
      respawn_q <= (next_state == S_RESPAWN);
      banner_q  <= banner_nxt;
      over_q    <= (next_state == S_GAME_OVER);
      step_q    <= step_nxt;
    end
  end

  assign bus.freeze        = freeze_q;
  assign bus.pm_death_anim = anim_q;
  assign bus.anim_step     = step_q;
  assign bus.ghosts_hidden = hidden_q;
  assign bus.respawn       = respawn_q;
  assign bus.ready_banner  = banner_q;
  assign bus.game_over     = over_q;

endmodule

// File: tb/tb_death_sequencer.sv
// Directed bench for death_sequencer with short frame constants and a 10-clock frame.
// Table of per-frame expectations plus hand-written corner sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_death_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  death_sequencer_if bus();

  death_sequencer #(
    .FREEZE_FRAMES  (2),
    .ANIM_STEP_FRMS (2),
    .ANIM_STEPS     (3),
    .READY_FRAMES   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {freeze, pm_death_anim, anim_step[3:0], ghosts_hidden, respawn, ready_banner, game_over}
  logic [9:0] obs_w;
  assign obs_w = {bus.freeze, bus.pm_death_anim, bus.anim_step, bus.ghosts_hidden,
                  bus.respawn, bus.ready_banner, bus.game_over};

  typedef struct {
    logic       ll;       // lost_life pulse on cycle 3 of the frame
    logic [9:0] exp_sof;  // outputs just after the frame's start_of_frame edge
    logic [9:0] exp_end;  // outputs after the last cycle of the frame
    int         resp;     // respawn pulses seen during the frame
  } vec_t;

  vec_t vecs[11];

  int total  = 0;
  int passed = 0;
  int resp_cnt = 0;

  logic [9:0] O_IDLE, O_FRZ, O_A0, O_A1, O_A2, O_RSP, O_RDY, O_GO;

  function automatic logic [9:0] enc(input logic f, input logic a, input logic [3:0] s,
                                     input logic h, input logic r, input logic b, input logic g);
    return {f, a, s, h, r, b, g};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc(input logic s, input logic l, input logic g);
    @(negedge clk);
    bus.start_of_frame = s;
    bus.lost_life      = l;
    bus.game_started   = g;
    @(posedge clk);
    #1;
    if (bus.respawn) resp_cnt++;
  endtask

  task automatic fill(input bit last_life);
    vecs[0]  = '{1'b1, O_IDLE, O_FRZ, 0};
    vecs[1]  = '{1'b0, O_FRZ,  O_FRZ, 0};
    vecs[2]  = '{1'b0, O_A0,   O_A0,  0};
    vecs[3]  = '{1'b0, O_A0,   O_A0,  0};
    vecs[4]  = '{1'b0, O_A1,   O_A1,  0};
    vecs[5]  = '{1'b0, O_A1,   O_A1,  0};
    vecs[6]  = '{1'b0, O_A2,   O_A2,  0};
    vecs[7]  = '{1'b0, O_A2,   O_A2,  0};
    if (last_life) begin
      vecs[8]  = '{1'b0, O_GO,   O_GO,   0};
      vecs[9]  = '{1'b0, O_GO,   O_GO,   0};
      vecs[10] = '{1'b0, O_GO,   O_GO,   0};
    end else begin
      vecs[8]  = '{1'b0, O_RSP,  O_RDY,  1};
      vecs[9]  = '{1'b0, O_RDY,  O_RDY,  0};
      vecs[10] = '{1'b0, O_IDLE, O_IDLE, 0};
    end
  endtask

  // One table entry per frame; extra_ll adds ignored lost_life pulses in ANIM (frame 5) and READY (frame 9).
  task automatic run_table(input string tag, input int n, input logic [2:0] lv, input bit extra_ll);
    for (int i = 0; i < n; i++) begin
      bus.lives = lv;
      resp_cnt  = 0;
      cyc(1'b1, 1'b0, 1'b1);
      chk($sformatf("%s_v%0d_sof", tag, i), int'(obs_w), int'(vecs[i].exp_sof));
      for (int c = 1; c < 10; c++)
        cyc(1'b0, (c == 3) && (vecs[i].ll || (extra_ll && (i == 5 || i == 9))), 1'b1);
      chk($sformatf("%s_v%0d_end", tag, i), int'(obs_w), int'(vecs[i].exp_end));
      chk($sformatf("%s_v%0d_resp", tag, i), resp_cnt, vecs[i].resp);
    end
  endtask

  initial begin
    int bad;
    O_IDLE = '0;
    O_FRZ  = enc(1, 0, 4'd0, 0, 0, 0, 0);
    O_A0   = enc(1, 1, 4'd0, 1, 0, 0, 0);
    O_A1   = enc(1, 1, 4'd1, 1, 0, 0, 0);
    O_A2   = enc(1, 1, 4'd2, 1, 0, 0, 0);
    O_RSP  = enc(1, 0, 4'd0, 0, 1, 0, 0);
    O_RDY  = enc(1, 0, 4'd0, 0, 0, 1, 0);
    O_GO   = enc(1, 0, 4'd0, 1, 0, 0, 1);

    reset = 1'b1;
    bus.start_of_frame = 1'b0;
    bus.lost_life      = 1'b0;
    bus.game_started   = 1'b1;
    bus.lives          = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'(obs_w), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    chk("idle_after_reset", int'(obs_w), 0);

    // Normal death with lives remaining.
    fill(1'b0);
    run_table("normal", 11, 3'd2, 1'b0);

    // Same death with stray lost_life pulses in ANIM and READY.
    run_table("ignored_ll", 11, 3'd2, 1'b1);

    // lost_life coincident with start_of_frame; FREEZE must still span two later frames.
    cyc(1'b1, 1'b1, 1'b1);
    chk("coinc_enter", int'(obs_w), int'(O_FRZ));
    repeat (9) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("coinc_frame1", int'(obs_w), int'(O_FRZ));
    repeat (9) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("coinc_frame2", int'(obs_w), int'(O_A0));
    repeat (9) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (9) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("abort_pre_step1", int'(obs_w), int'(O_A1));

    // Abort mid-ANIM at step 1.
    resp_cnt = 0;
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_idle", int'(obs_w), 0);
    chk("abort_step0", int'(bus.anim_step), 0);
    for (int f = 0; f < 3; f++) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      repeat (8) cyc(1'b0, 1'b0, 1'b1);
    end
    chk("abort_stays_idle", int'(obs_w), 0);
    chk("abort_no_respawn", resp_cnt, 0);

    // Last life: game over latched and held, cleared by dropping game_started.
    fill(1'b1);
    run_table("last_life", 9, 3'd0, 1'b0);
    bad = 0;
    resp_cnt = 0;
    for (int f = 0; f < 100; f++) begin
      for (int c = 0; c < 10; c++) begin
        cyc(c == 0, 1'b0, 1'b1);
        if (obs_w != O_GO) bad++;
      end
    end
    chk("go_hold_100_frames", bad, 0);
    chk("go_no_respawn", resp_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("go_abort", int'(obs_w), 0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("go_abort_idle", int'(obs_w), 0);

    // Reset pulse in FREEZE clears outputs without a clock edge.
    bus.lives = 3'd2;
    cyc(1'b0, 1'b1, 1'b1);
    chk("rst_pre_freeze", int'(obs_w), int'(O_FRZ));
    cyc(1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_clear", int'(obs_w), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    chk("rst_released_idle", int'(obs_w), 0);

    // Full sequence again after the reset.
    fill(1'b0);
    run_table("post_reset", 11, 3'd2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
